// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath constants, load/store size encoding
// and small decode helpers used by the memory stage.
package pipeline_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_e;

    // True for the five funct3 encodings that describe a real memory access.
    function automatic logic lsu_size_valid(input logic [2:0] funct3);
        lsu_size_valid = (funct3 == LSU_B)  || (funct3 == LSU_H)  ||
                         (funct3 == LSU_W)  || (funct3 == LSU_BU) ||
                         (funct3 == LSU_HU);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: byte-enable synchronous write, combinational
// read.
module data_mem #(
  parameter int    WORD_ADDR_BITS = 15,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [3:0]                be,
  input  logic [WORD_ADDR_BITS-1:0] addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we && be[lane]) begin
        mem[addr][lane*8 +: 8] <= wdata[lane*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage with the MEM/WB pipeline register: lane alignment,
// sign/zero extension, misalignment detection and data memory access.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int    DATA_WIDTH    = pipeline_pkg::DATA_WIDTH,
    parameter int    MEM_ADDR_BITS = 17,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  MUXJUMPM,
    input  logic                  JUMPRTM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [DATA_WIDTH-1:0] PCTargetM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic                  MUXJUMPW,
    output logic                  JUMPRTW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCTargetW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  MisalignW
);

    lsu_size_e             size;
    logic [1:0]            lane;
    logic                  size_ok;
    logic                  misalign;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] load_data;

    assign size = lsu_size_e'(funct3M);
    assign lane = ALUResultM[1:0];

    // Store lane steering: the source byte/half is replicated so every
    // enabled lane already carries the right bits.
    always_comb begin
        size_ok    = lsu_size_valid(funct3M);
        misalign   = 1'b0;
        byte_en    = 4'b0000;
        store_data = WriteDataM;
        case (size)
            LSU_B, LSU_BU: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{WriteDataM[7:0]}};
            end
            LSU_H, LSU_HU: begin
                misalign   = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{WriteDataM[15:0]}};
            end
            LSU_W: begin
                misalign = (lane != 2'b00);
                byte_en  = 4'b1111;
            end
            default: ;
        endcase
    end

    assign mem_we = MemWriteM && !rst && size_ok && !misalign;

    data_mem #(
        .WORD_ADDR_BITS (MEM_ADDR_BITS - 2),
        .INIT_FILE      (MEM_INIT_FILE)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (byte_en),
        .addr  (ALUResultM[MEM_ADDR_BITS-1:2]),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

    assign lane_data = mem_rdata >> {lane, 3'b000};

    always_comb begin
        load_ext = '0;
        case (size)
            LSU_B:   load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            LSU_BU:  load_ext = {24'h0, lane_data[7:0]};
            LSU_H:   load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            LSU_HU:  load_ext = {16'h0, lane_data[15:0]};
            LSU_W:   load_ext = lane_data;
            default: load_ext = '0;
        endcase
    end

    assign load_data = (MemWriteM || misalign) ? '0 : load_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            MUXJUMPW   <= 1'b0;
            JUMPRTW    <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCTargetW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            MUXJUMPW   <= MUXJUMPM;
            JUMPRTW    <= JUMPRTM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            PCTargetW  <= PCTargetM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            MisalignW  <= misalign;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised bench for memory_stage against a byte-addressed reference memory.
module tb_memory_stage;

    localparam int AB = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, ResultSrcM, MemWriteM, MUXJUMPM, JUMPRTM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCTargetM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteW, ResultSrcW, MUXJUMPW, JUMPRTW, MisalignW;
    logic [31:0] ALUResultW, ReadDataW, PCTargetW, PCPlus4W;
    logic [4:0]  RdW;

    memory_stage #(
        .DATA_WIDTH    (32),
        .MEM_ADDR_BITS (AB),
        .MEM_INIT_FILE ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .MUXJUMPM   (MUXJUMPM),
        .JUMPRTM    (JUMPRTM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCTargetM  (PCTargetM),
        .PCPlus4M   (PCPlus4M),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .MUXJUMPW   (MUXJUMPW),
        .JUMPRTW    (JUMPRTW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCTargetW  (PCTargetW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .MisalignW  (MisalignW)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference memory covers byte offsets 0..1023 (after modulo 2**AB).
    logic [7:0] ref_bytes [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bytes_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int off;
        logic [31:0] v;
        off = int'(a % (32'd1 << AB));
        v = 32'h0;
        for (int k = 0; k < bytes_of(f3); k++) v = v | (32'(ref_bytes[off + k]) << (8 * k));
        case (f3)
            3'd0:    if (v >= 32'h80)   v = v - 32'h100;
            3'd1:    if (v >= 32'h8000) v = v - 32'h10000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic issue(input logic mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic rw, input logic rs,
                         input logic mj, input logic jr, input logic [4:0] rd,
                         input logic [31:0] pct, input logic [31:0] pc4);
        logic [31:0] exp_data;
        bit ok;
        bit mis;
        int off;
        MemWriteM = mw; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        RegWriteM = rw; ResultSrcM = rs; MUXJUMPM = mj; JUMPRTM = jr;
        RdM = rd; PCTargetM = pct; PCPlus4M = pc4;
        ok  = model_valid(f3);
        mis = model_misaligned(f3, a);
        exp_data = 32'h0;
        if (!mw && ok && !mis) exp_data = model_load(f3, a);
        if (mw && ok && !mis) begin
            off = int'(a % (32'd1 << AB));
            for (int k = 0; k < bytes_of(f3); k++) ref_bytes[off + k] = wd[8*k +: 8];
        end
        @(posedge clk);
        #1;
        check("read_data", ReadDataW, exp_data);
        check("misalign", {31'h0, MisalignW}, {31'h0, mis});
        check("alu_result", ALUResultW, a);
        check("pc_target", PCTargetW, pct);
        check("pc_plus4", PCPlus4W, pc4);
        check("ctrl", {27'h0, RegWriteW, ResultSrcW, MUXJUMPW, JUMPRTW, 1'b0},
                      {27'h0, rw, rs, mj, jr, 1'b0});
        check("rd", {27'h0, RdW}, {27'h0, rd});
    endtask

    task automatic op(input logic mw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        issue(mw, f3, a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom(), $urandom());
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_ctrl"}, {28'h0, RegWriteW, ResultSrcW, MUXJUMPW, JUMPRTW}, 32'h0);
        check({tag, "_misalign_rd"}, {26'h0, MisalignW, RdW}, 32'h0);
        check({tag, "_alu"}, ALUResultW, 32'h0);
        check({tag, "_rdata"}, ReadDataW, 32'h0);
        check({tag, "_pct"}, PCTargetW, 32'h0);
        check({tag, "_pc4"}, PCPlus4W, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int off;

        rst = 1'b1;
        RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; MUXJUMPM = 0; JUMPRTM = 0;
        funct3M = 3'd0; ALUResultM = 0; WriteDataM = 0; RdM = 0; PCTargetM = 0; PCPlus4M = 0;
        repeat (2) @(posedge clk);
        #1;
        check_w_zero("reset0");
        rst = 1'b0;

        // Fill the modelled region with known words.
        for (int i = 0; i < 256; i++) op(1'b1, 3'd2, 32'(i * 4), $urandom());

        op(1'b1, 3'd2, 32'h100, 32'h12345678);
        op(1'b0, 3'd2, 32'h100, 32'h0);
        check("lw_0x100", ReadDataW, 32'h12345678);

        op(1'b1, 3'd0, 32'h203, 32'hABCDEF80);
        op(1'b0, 3'd0, 32'h203, 32'h0);
        check("lb_0x203", ReadDataW, 32'hFFFFFF80);
        op(1'b0, 3'd4, 32'h203, 32'h0);
        check("lbu_0x203", ReadDataW, 32'h00000080);
        op(1'b0, 3'd2, 32'h200, 32'h0);
        check("lw_0x200_byte3", {24'h0, ReadDataW[31:24]}, 32'h80);

        op(1'b1, 3'd1, 32'h101, 32'h0000BEEF);
        check("sh_0x101_misalign", {31'h0, MisalignW}, 32'h1);
        op(1'b0, 3'd2, 32'h100, 32'h0);
        check("lw_0x100_after_sh", ReadDataW, 32'h12345678);
        op(1'b0, 3'd2, 32'h102, 32'h0);
        check("lw_0x102_data", ReadDataW, 32'h0);
        check("lw_0x102_misalign", {31'h0, MisalignW}, 32'h1);

        op(1'b1, 3'd2, (32'd1 << AB) + 32'h10, 32'hCAFEF00D);
        op(1'b0, 3'd2, 32'h10, 32'h0);
        check("wrap_lw_0x10", ReadDataW, 32'hCAFEF00D);

        issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h80, 32'h44);
        check("pass_rd", {27'h0, RdW}, 32'd7);
        check("pass_pc4", PCPlus4W, 32'h44);
        check("pass_pct", PCTargetW, 32'h80);
        check("pass_muxjump", {31'h0, MUXJUMPW}, 32'h1);

        // Reset with a pending store aimed (via alias) at word 0.
        op(1'b1, 3'd2, 32'h0, 32'hDEADBEEF);
        rst = 1'b1;
        RegWriteM = 1; ResultSrcM = 1; MemWriteM = 1; MUXJUMPM = 1; JUMPRTM = 1;
        funct3M = 3'd2; ALUResultM = 32'd1 << AB; WriteDataM = 32'h11111111;
        RdM = 5'd9; PCTargetM = 32'h1234; PCPlus4M = 32'h5678;
        repeat (2) @(posedge clk);
        #1;
        check_w_zero("reset1");
        rst = 1'b0;
        op(1'b0, 3'd2, 32'h0, 32'h0);
        check("word0_after_reset", ReadDataW, 32'hDEADBEEF);

        for (int i = 0; i < 600; i++) begin
            off = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) off = off & ~3;
            a = 32'(off);
            if ($urandom_range(0, 1) != 0) a = a | ($urandom() & 32'hFFFE0000);
            op(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
